nvram_dump: RTL and testbench

NVRAM_DUMP -- requirements
Module: nvram_dump

---
 rtl/nvram_pkg.sv | 26 ++
 rtl/nvram_pause_sync.sv | 53 +++++
 rtl/nvram_dump.sv | 170 +++++++++++++++++
 tb/tb_nvram_dump.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nvram_pkg.sv
// Shared types and constants for the NVRAM dump block.
package nvram_pkg;

   localparam int unsigned DATA_W  = 8;
   localparam int unsigned INDEX_W = 8;
   localparam int unsigned IOADR_W = 25;

   // Byte returned to the HPS for addresses beyond the dump region
   localparam logic [DATA_W-1:0] OOR_FILL = 8'hFF;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_HALT    = 3'd1,
      ST_SETTLE  = 3'd2,
      ST_READY   = 3'd3,
      ST_FETCH   = 3'd4,
      ST_CAPTURE = 3'd5,
      ST_RESUME  = 3'd6
   } state_e;

   // Counter width able to hold pad-1 (at least one bit)
   function automatic int unsigned cnt_width(input int unsigned pad);
      return (pad <= 2) ? 1 : $clog2(pad);
   endfunction

endpackage

// File: rtl/nvram_pause_sync.sv
// Pause handshake for the dump FSM: decides when a halted CPU has been
// paused long enough (PAUSEPAD cycles) to start serving data.
module nvram_pause_sync
   import nvram_pkg::*;
#(
   parameter int unsigned PAUSEPAD = 2
) (
   input  logic clk_sys,
   input  logic reset,
   input  logic in_halt,
   input  logic in_settle,
   input  logic paused,
   output logic settle_go_c,
   output logic settle_done_c,
   output logic settle_lost_c
);

   localparam int unsigned    CNT_W    = cnt_width(PAUSEPAD);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((PAUSEPAD > 0) ? (PAUSEPAD - 1) : 0);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Handshake decisions and settle counter next value
   always_comb begin
      settle_go_c   = 1'b0;
      settle_done_c = 1'b0;
      settle_lost_c = 1'b0;
      cnt_d         = '0;
      if (in_halt && paused) begin
         settle_go_c = 1'b1;
      end
      if (in_settle) begin
         if (!paused) begin
            settle_lost_c = 1'b1;
         end else if (cnt_q == CNT_LAST) begin
            settle_done_c = 1'b1;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   // Settle counter register; cleared whenever the FSM is outside SETTLE
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/nvram_dump.sv
// Serves the game CMOS RAM to the HPS as an upload: halts the CPU, waits
// for it to settle, then answers byte reads with a fixed 3-cycle latency.
// Optional autosave request on OSD close is enabled by NVRAM_AUTOSAVE_EN.
module nvram_dump
   import nvram_pkg::*;
#(
   parameter int unsigned DUMPWIDTH = 8,
   parameter int unsigned DUMPINDEX = 4,
   parameter int unsigned PAUSEPAD  = 2
) (
   input  logic                 clk_sys,
   input  logic                 reset,
   input  logic                 ioctl_upload,
   input  logic [INDEX_W-1:0]   ioctl_index,
   input  logic [IOADR_W-1:0]   ioctl_addr,
   input  logic                 ioctl_rd,
   output logic [DATA_W-1:0]    ioctl_din,
   output logic                 ioctl_wait,
   output logic                 ioctl_upload_req,
   input  logic                 osd_status,
   input  logic                 autosave,
   output logic                 pause_cpu,
   input  logic                 paused,
   output logic [DUMPWIDTH-1:0] mem_addr,
   input  logic [DATA_W-1:0]    mem_data,
   output logic                 done
);

   state_e                state_q;
   state_e                state_d;
   logic                  pause_d;
   logic                  wait_d;
   logic                  done_d;
   logic [DATA_W-1:0]     din_d;
   logic [DUMPWIDTH-1:0]  maddr_d;
   logic                  oor_q;
   logic                  oor_d;
   logic                  sel_c;
   logic                  rd_oor_c;
   logic                  settle_go_c;
   logic                  settle_done_c;
   logic                  settle_lost_c;

   assign sel_c    = ioctl_upload && (ioctl_index == INDEX_W'(DUMPINDEX));
   assign rd_oor_c = (ioctl_addr >> DUMPWIDTH) != '0;

   nvram_pause_sync #(
      .PAUSEPAD (PAUSEPAD)
   ) u_pause_sync (
      .clk_sys       (clk_sys),
      .reset         (reset),
      .in_halt       (state_q == ST_HALT),
      .in_settle     (state_q == ST_SETTLE),
      .paused        (paused),
      .settle_go_c   (settle_go_c),
      .settle_done_c (settle_done_c),
      .settle_lost_c (settle_lost_c)
   );

   // Next state and next registered outputs
   always_comb begin
      state_d = state_q;
      pause_d = pause_cpu;
      wait_d  = ioctl_wait;
      done_d  = 1'b0;
      din_d   = ioctl_din;
      maddr_d = mem_addr;
      oor_d   = oor_q;

      case (state_q)
         ST_IDLE: begin
            if (sel_c) begin
               state_d = ST_HALT;
               pause_d = 1'b1;
               wait_d  = 1'b1;
            end
         end
         ST_HALT: begin
            if (settle_go_c) begin
               state_d = ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            if (settle_lost_c) begin
               state_d = ST_HALT;
            end else if (settle_done_c) begin
               state_d = ST_READY;
               wait_d  = 1'b0;
            end
         end
         ST_READY: begin
            if (ioctl_rd) begin
               state_d = ST_FETCH;
               wait_d  = 1'b1;
               oor_d   = rd_oor_c;
               if (!rd_oor_c) begin
                  maddr_d = ioctl_addr[DUMPWIDTH-1:0];
               end
            end
         end
         ST_FETCH: begin
            state_d = ST_CAPTURE;
         end
         ST_CAPTURE: begin
            din_d   = oor_q ? OOR_FILL : mem_data;
            wait_d  = 1'b0;
            state_d = ST_READY;
         end
         ST_RESUME: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            pause_d = 1'b0;
            wait_d  = 1'b0;
         end
      endcase

      // HPS abandoned the upload: release the CPU at once, drop any fetch
      if ((state_q != ST_IDLE) && (state_q != ST_RESUME) && !ioctl_upload) begin
         state_d = ST_RESUME;
         pause_d = 1'b0;
         wait_d  = 1'b0;
         done_d  = 1'b1;
         din_d   = ioctl_din;
      end
   end

   // State and output registers
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         pause_cpu  <= 1'b0;
         ioctl_wait <= 1'b0;
         done       <= 1'b0;
         ioctl_din  <= '0;
         mem_addr   <= '0;
         oor_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         pause_cpu  <= pause_d;
         ioctl_wait <= wait_d;
         done       <= done_d;
         ioctl_din  <= din_d;
         mem_addr   <= maddr_d;
         oor_q      <= oor_d;
      end
   end

`ifdef NVRAM_AUTOSAVE_EN
   logic osd_q;

   // Request an upload when the OSD closes with autosave on and nothing in flight
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         osd_q            <= 1'b0;
         ioctl_upload_req <= 1'b0;
      end else begin
         osd_q            <= osd_status;
         ioctl_upload_req <= osd_q && !osd_status && autosave && (state_q == ST_IDLE);
      end
   end
`else
   logic unused_autosave;

   assign ioctl_upload_req = 1'b0;
   assign unused_autosave  = &{1'b0, osd_status, autosave};
`endif

endmodule

// File: tb/tb_nvram_dump.sv
// Scoreboard bench for nvram_dump: stimulus queues expected events,
// a negedge monitor pops and compares when the DUT produces them.
module tb_nvram_dump;

   localparam int unsigned DW  = 8;
   localparam int unsigned IDX = 4;
   localparam int unsigned PAD = 2;

   localparam int K_HALT  = 0;
   localparam int K_READ  = 1;
   localparam int K_DONE  = 2;
   localparam int K_UPREQ = 3;

`ifdef NVRAM_AUTOSAVE_EN
   localparam int EXP_REQ = 1;
`else
   localparam int EXP_REQ = 0;
`endif

   typedef struct {
      int         kind;
      logic [7:0] din;
      logic [7:0] maddr;
      int         t0;
      int         lat;
      int         whi;
   } exp_t;

   logic          clk_sys = 1'b0;
   logic          reset = 1'b1;
   logic          ioctl_upload = 1'b0;
   logic [7:0]    ioctl_index = 8'd0;
   logic [24:0]   ioctl_addr = 25'd0;
   logic          ioctl_rd = 1'b0;
   logic [7:0]    ioctl_din;
   logic          ioctl_wait;
   logic          ioctl_upload_req;
   logic          osd_status = 1'b0;
   logic          autosave = 1'b0;
   logic          pause_cpu;
   logic          paused = 1'b0;
   logic [DW-1:0] mem_addr;
   logic [7:0]    mem_data = 8'd0;
   logic          done;

   logic [7:0]    ram [256];
   exp_t          exp_q [$];
   int            n_checks = 0;
   int            n_pass = 0;
   int            cyc = 0;
   int            whi = 0;
   int            upreq_seen = 0;
   logic          prev_wait = 1'b0;
   logic          prev_done = 1'b0;
   logic          prev_req = 1'b0;

   nvram_dump #(
      .DUMPWIDTH (DW),
      .DUMPINDEX (IDX),
      .PAUSEPAD  (PAD)
   ) dut (
      .clk_sys          (clk_sys),
      .reset            (reset),
      .ioctl_upload     (ioctl_upload),
      .ioctl_index      (ioctl_index),
      .ioctl_addr       (ioctl_addr),
      .ioctl_rd         (ioctl_rd),
      .ioctl_din        (ioctl_din),
      .ioctl_wait       (ioctl_wait),
      .ioctl_upload_req (ioctl_upload_req),
      .osd_status       (osd_status),
      .autosave         (autosave),
      .pause_cpu        (pause_cpu),
      .paused           (paused),
      .mem_addr         (mem_addr),
      .mem_data         (mem_data),
      .done             (done)
   );

   always #5 clk_sys = ~clk_sys;

   always @(posedge clk_sys) cyc <= cyc + 1;

   // CMOS RAM model with one-cycle read latency
   always @(posedge clk_sys) mem_data <= ram[mem_addr];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic push_exp(input int kind, input logic [7:0] din, input logic [7:0] maddr,
                           input int lat, input int w);
      exp_t e;
      e.kind = kind; e.din = din; e.maddr = maddr; e.t0 = cyc; e.lat = lat; e.whi = w;
      exp_q.push_back(e);
   endtask

   task automatic pop_exp(output exp_t e, output bit ok);
      ok = 1'b0;
      e.kind = -1; e.din = '0; e.maddr = '0; e.t0 = 0; e.lat = 0; e.whi = 0;
      if (exp_q.size() == 0) check("unexpected_event", 32'(exp_q.size()), 32'd1);
      else begin
         e  = exp_q.pop_front();
         ok = 1'b1;
      end
   endtask

   // Monitor: compares DUT events against the scoreboard queue
   always @(negedge clk_sys) begin
      exp_t e;
      bit   ok;
      if (!reset) begin
         if (prev_done) check("done_width", 32'(done), 32'd0);
         if (prev_req)  check("upreq_width", 32'(ioctl_upload_req), 32'd0);
         if (done) begin
            pop_exp(e, ok);
            if (ok) begin
               check("done_kind", 32'(e.kind), 32'(K_DONE));
               check("done_latency", 32'(cyc - e.t0), 32'(e.lat));
               check("done_pause_cpu", 32'(pause_cpu), 32'd0);
               check("done_wait", 32'(ioctl_wait), 32'd0);
            end
         end else if (prev_wait && !ioctl_wait) begin
            pop_exp(e, ok);
            if (ok) begin
               check("release_kind", 32'(e.kind == K_HALT || e.kind == K_READ), 32'd1);
               check("release_latency", 32'(cyc - e.t0), 32'(e.lat));
               check("release_pause_cpu", 32'(pause_cpu), 32'd1);
               if (e.kind == K_HALT) check("halt_wait_cycles", 32'(whi), 32'(e.whi));
               if (e.kind == K_READ) begin
                  check("read_din", 32'(ioctl_din), 32'(e.din));
                  check("read_mem_addr", 32'(mem_addr), 32'(e.maddr));
               end
            end
         end
         if (ioctl_upload_req) begin
            upreq_seen++;
            pop_exp(e, ok);
            if (ok) check("upreq_kind", 32'(e.kind), 32'(K_UPREQ));
         end
      end
      whi       = ioctl_wait ? whi + 1 : 0;
      prev_wait = ioctl_wait;
      prev_done = done;
      prev_req  = ioctl_upload_req;
   end

   task automatic wait_release(input string name);
      int n = 0;
      while (ioctl_wait && n < 64) begin
         @(negedge clk_sys);
         n++;
      end
      check(name, 32'(ioctl_wait), 32'd0);
   endtask

   // One HPS read; release expected 3 cycles after rd is driven
   task automatic hps_read(input logic [24:0] addr, input logic [7:0] din, input logic [7:0] maddr);
      push_exp(K_READ, din, maddr, 3, -1);
      ioctl_addr = addr;
      ioctl_rd   = 1'b1;
      @(negedge clk_sys);
      ioctl_rd   = 1'b0;
      wait_release("read_timeout");
      @(negedge clk_sys);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) ram[i] = 8'(i) ^ 8'hA5;
      ram[8'h10] = 8'h5A;
      ram[8'h7F] = 8'hDA;

      // Reset values
      repeat (3) @(negedge clk_sys);
      check("rst_pause_cpu", 32'(pause_cpu), 32'd0);
      check("rst_wait", 32'(ioctl_wait), 32'd0);
      check("rst_upload_req", 32'(ioctl_upload_req), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_din", 32'(ioctl_din), 32'h00);
      check("rst_mem_addr", 32'(mem_addr), 32'd0);
      reset = 1'b0;
      @(negedge clk_sys);

      // Upload of the dump index; CPU acknowledges pause 5 cycles later
      push_exp(K_HALT, 8'h00, 8'h00, 1 + 5 + PAD, 5 + PAD);
      ioctl_index  = 8'(IDX);
      ioctl_upload = 1'b1;
      repeat (5) @(posedge clk_sys);
      @(negedge clk_sys);
      paused = 1'b1;
      wait_release("halt_timeout");
      check("ready_pause_cpu", 32'(pause_cpu), 32'd1);
      @(negedge clk_sys);

      // Reads: in range, out of range (no memory access), boundary
      hps_read(25'h010, 8'h5A, 8'h10);
      hps_read(25'h100, 8'hFF, 8'h10);
      hps_read(25'h07F, 8'hDA, 8'h7F);
      hps_read(25'h1FF, 8'hFF, 8'h7F);

      // Upload dropped while a fetch is in flight
      ioctl_addr = 25'h020;
      ioctl_rd   = 1'b1;
      @(negedge clk_sys);
      ioctl_rd     = 1'b0;
      ioctl_upload = 1'b0;
      push_exp(K_DONE, 8'h00, 8'h00, 1, -1);
      repeat (3) @(negedge clk_sys);
      paused = 1'b0;
      check("abort_din_kept", 32'(ioctl_din), 32'hFF);
      @(negedge clk_sys);

      // Second upload: rd during HALT ignored, paused glitch restarts settle
      push_exp(K_HALT, 8'h00, 8'h00, 1 + 5 + PAD, 5 + PAD);
      ioctl_upload = 1'b1;
      @(posedge clk_sys);
      @(negedge clk_sys);
      ioctl_addr = 25'h033;
      ioctl_rd   = 1'b1;
      @(negedge clk_sys);
      ioctl_rd = 1'b0;
      @(negedge clk_sys);
      paused = 1'b1;
      @(negedge clk_sys);
      paused = 1'b0;
      @(negedge clk_sys);
      paused = 1'b1;
      wait_release("halt2_timeout");
      check("halt_rd_ignored", 32'(mem_addr), 32'h20);
      @(negedge clk_sys);
      hps_read(25'h010, 8'h5A, 8'h10);

      // Synchronous reset while READY
      reset        = 1'b1;
      ioctl_upload = 1'b0;
      paused       = 1'b0;
      @(negedge clk_sys);
      check("rst2_pause_cpu", 32'(pause_cpu), 32'd0);
      check("rst2_wait", 32'(ioctl_wait), 32'd0);
      check("rst2_din", 32'(ioctl_din), 32'h00);
      check("rst2_mem_addr", 32'(mem_addr), 32'd0);
      check("rst2_done", 32'(done), 32'd0);
      reset = 1'b0;
      @(negedge clk_sys);

      // Upload of a different index leaves everything alone
      ioctl_index  = 8'd1;
      ioctl_upload = 1'b1;
      paused       = 1'b1;
      repeat (6) @(negedge clk_sys);
      check("other_idx_pause_cpu", 32'(pause_cpu), 32'd0);
      check("other_idx_wait", 32'(ioctl_wait), 32'd0);
      check("other_idx_din", 32'(ioctl_din), 32'h00);
      ioctl_upload = 1'b0;
      paused       = 1'b0;
      repeat (2) @(negedge clk_sys);

      // Autosave on OSD close, then with autosave off
      autosave   = 1'b1;
      osd_status = 1'b1;
      repeat (3) @(negedge clk_sys);
      if (EXP_REQ != 0) push_exp(K_UPREQ, 8'h00, 8'h00, 0, -1);
      osd_status = 1'b0;
      repeat (4) @(negedge clk_sys);
      check("upreq_count_on", 32'(upreq_seen), 32'(EXP_REQ));
      autosave   = 1'b0;
      osd_status = 1'b1;
      repeat (3) @(negedge clk_sys);
      osd_status = 1'b0;
      repeat (4) @(negedge clk_sys);
      check("upreq_count_off", 32'(upreq_seen), 32'(EXP_REQ));

      repeat (4) @(negedge clk_sys);
      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
